// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-entry retire and mispredict flush.
// Define ROB_CDB_BYPASS_EN to forward the live CDB result onto the query ports.
module rob_commit #(
   parameter int ROB_DEPTH = 16,
   parameter int ROB_AW    = 4,
   parameter int REG_AW    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              in_issue_flag,
   input  logic [REG_AW-1:0] in_issue_dest_reg,
   output logic [ROB_AW-1:0] out_issue_rob,
   output logic              out_full,
   input  logic              in_cdb_flag,
   input  logic [ROB_AW-1:0] in_cdb_rob,
   input  logic [31:0]       in_cdb_value,
   input  logic              in_cdb_xbp,
   input  logic [ROB_AW-1:0] in_query_rob1,
   input  logic [ROB_AW-1:0] in_query_rob2,
   output logic              out_query_ready1,
   output logic              out_query_ready2,
   output logic [31:0]       out_query_value1,
   output logic [31:0]       out_query_value2,
   output logic [REG_AW-1:0] out_commit_reg,
   output logic [ROB_AW-1:0] out_commit_rob,
   output logic [31:0]       out_commit_value,
   output logic              out_xbp
);

   logic [ROB_AW-1:0]                head, tail;
   logic [ROB_AW:0]                  count;
   logic [ROB_DEPTH-1:0]             busy, done, xbp;
   logic [ROB_DEPTH-1:0][REG_AW-1:0] dest;
   logic [ROB_DEPTH-1:0][31:0]       value;

   logic issue_go, cdb_go, commit_go, flush;

   assign out_full      = (count == (ROB_AW+1)'(ROB_DEPTH));
   assign out_issue_rob = tail;

   // The cycle after a flush still sees stale issue/CDB traffic; drop it.
   assign issue_go  = rdy & in_issue_flag & ~out_full & ~out_xbp;
   assign cdb_go    = rdy & in_cdb_flag & busy[in_cdb_rob] & ~out_xbp;
   assign commit_go = rdy & busy[head] & done[head];
   assign flush     = commit_go & xbp[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         busy             <= '0;
         done             <= '0;
         xbp              <= '0;
         dest             <= '0;
         value            <= '0;
         out_commit_reg   <= '0;
         out_commit_rob   <= '0;
         out_commit_value <= '0;
         out_xbp          <= 1'b0;
      end else if (rdy) begin
         out_commit_reg <= '0;
         out_xbp        <= 1'b0;
         if (commit_go) begin
            out_commit_reg   <= dest[head];
            out_commit_rob   <= head;
            out_commit_value <= value[head];
            out_xbp          <= xbp[head];
         end
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
            xbp   <= '0;
         end else begin
            if (cdb_go) begin
               done[in_cdb_rob]  <= 1'b1;
               value[in_cdb_rob] <= in_cdb_value;
               xbp[in_cdb_rob]   <= in_cdb_xbp;
            end
            // Retire after the CDB write so a same-edge write to head cannot revive it.
            if (commit_go) begin
               busy[head] <= 1'b0;
               done[head] <= 1'b0;
               head       <= head + ROB_AW'(1);
            end
            if (issue_go) begin
               busy[tail] <= 1'b1;
               done[tail] <= 1'b0;
               xbp[tail]  <= 1'b0;
               dest[tail] <= in_issue_dest_reg;
               tail       <= tail + ROB_AW'(1);
            end
            count <= count + (ROB_AW+1)'(issue_go) - (ROB_AW+1)'(commit_go);
         end
      end
   end

   always_comb begin
      out_query_ready1 = busy[in_query_rob1] & done[in_query_rob1];
      out_query_value1 = value[in_query_rob1];
      out_query_ready2 = busy[in_query_rob2] & done[in_query_rob2];
      out_query_value2 = value[in_query_rob2];
`ifdef ROB_CDB_BYPASS_EN
      if (in_cdb_flag && in_cdb_rob == in_query_rob1) begin
         out_query_ready1 = 1'b1;
         out_query_value1 = in_cdb_value;
      end
      if (in_cdb_flag && in_cdb_rob == in_query_rob2) begin
         out_query_ready2 = 1'b1;
         out_query_value2 = in_cdb_value;
      end
`endif
   end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus a randomized run against a queue model.
module tb_rob_commit;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int RW    = 5;

   logic          clk = 1'b0;
   logic          rst_n, rdy;
   logic          in_issue_flag;
   logic [RW-1:0] in_issue_dest_reg;
   logic [AW-1:0] out_issue_rob;
   logic          out_full;
   logic          in_cdb_flag;
   logic [AW-1:0] in_cdb_rob;
   logic [31:0]   in_cdb_value;
   logic          in_cdb_xbp;
   logic [AW-1:0] in_query_rob1, in_query_rob2;
   logic          out_query_ready1, out_query_ready2;
   logic [31:0]   out_query_value1, out_query_value2;
   logic [RW-1:0] out_commit_reg;
   logic [AW-1:0] out_commit_rob;
   logic [31:0]   out_commit_value;
   logic          out_xbp;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rob_commit #(.ROB_DEPTH(DEPTH), .ROB_AW(AW), .REG_AW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .in_issue_flag(in_issue_flag), .in_issue_dest_reg(in_issue_dest_reg),
      .out_issue_rob(out_issue_rob), .out_full(out_full),
      .in_cdb_flag(in_cdb_flag), .in_cdb_rob(in_cdb_rob),
      .in_cdb_value(in_cdb_value), .in_cdb_xbp(in_cdb_xbp),
      .in_query_rob1(in_query_rob1), .in_query_rob2(in_query_rob2),
      .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
      .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
      .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
      .out_commit_value(out_commit_value), .out_xbp(out_xbp)
   );

   // Reference model: program-ordered list of in-flight instructions.
   typedef struct {
      int          tag;
      logic [4:0]  dst;
      bit          fin;
      logic [31:0] val;
      bit          bad;
   } ent_t;
   ent_t        mq[$];
   int          m_next_tag;
   bit          m_flush_cyc;
   bit          e_commit;
   logic [4:0]  e_reg;
   logic [3:0]  e_rob;
   logic [31:0] e_val;
   logic        e_xbp;

   task automatic drive(input logic iss, input logic [RW-1:0] d, input logic cf,
                        input logic [AW-1:0] cr, input logic [31:0] cv, input logic cx);
      in_issue_flag     = iss;
      in_issue_dest_reg = d;
      in_cdb_flag       = cf;
      in_cdb_rob        = cr;
      in_cdb_value      = cv;
      in_cdb_xbp        = cx;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      drive(0, 0, 0, 0, 0, 0);
      in_query_rob1 = 0;
      in_query_rob2 = 0;
      rdy   = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      drive(0, 0, 0, 0, 0, 0);
      in_query_rob1 = 0;
      in_query_rob2 = 0;
      rdy   = 1'b1;
      rst_n = 1'b0;
      #3;
      checks++;
      if (out_full !== 1'b0 || out_issue_rob !== 4'd0) begin
         failures++;
         $display("FAIL reset_ptr: full=%0b issue_rob=%0d want 0/0", out_full, out_issue_rob);
      end
      checks++;
      if (out_commit_reg !== 5'd0 || out_xbp !== 1'b0 || out_commit_value !== 32'd0) begin
         failures++;
         $display("FAIL reset_commit: reg=%0d xbp=%0b val=%0h want 0", out_commit_reg, out_xbp, out_commit_value);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (out_commit_reg !== 5'd0 || out_issue_rob !== 4'd0) begin
         failures++;
         $display("FAIL reset_release: reg=%0d issue_rob=%0d want 0/0", out_commit_reg, out_issue_rob);
      end
   endtask

   task automatic test_fill;
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         drive(1, RW'(i), 0, 0, 0, 0);
         tick();
         checks++;
         if (out_full !== (i == 16)) begin
            failures++;
            $display("FAIL fill_full[%0d]: got %0b want %0b", i, out_full, (i == 16));
         end
      end
      drive(1, 5'd17, 0, 0, 0, 0);
      tick();
      checks++;
      if (out_full !== 1'b1 || out_issue_rob !== 4'd0 || out_commit_reg !== 5'd0) begin
         failures++;
         $display("FAIL fill_overflow: full=%0b tail=%0d reg=%0d want 1/0/0", out_full, out_issue_rob, out_commit_reg);
      end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_commit_basic;
      do_reset();
      drive(1, 5'd5, 0, 0, 0, 0);
      tick();
      drive(0, 0, 1, 4'd0, 32'h1234, 0);
      tick();
      checks++;
      if (out_commit_reg !== 5'd0) begin
         failures++;
         $display("FAIL basic_early: reg=%0d want 0", out_commit_reg);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (out_commit_reg !== 5'd5 || out_commit_rob !== 4'd0 || out_commit_value !== 32'h1234) begin
         failures++;
         $display("FAIL basic_commit: reg=%0d rob=%0d val=%0h want 5/0/1234", out_commit_reg, out_commit_rob, out_commit_value);
      end
      tick();
      checks++;
      if (out_commit_reg !== 5'd0) begin
         failures++;
         $display("FAIL basic_after: reg=%0d want 0", out_commit_reg);
      end
   endtask

   task automatic test_order;
      do_reset();
      drive(1, 5'd7, 0, 0, 0, 0);
      tick();
      drive(1, 5'd9, 0, 0, 0, 0);
      tick();
      drive(0, 0, 1, 4'd1, 32'hB, 0);
      tick();
      drive(0, 0, 1, 4'd0, 32'hA, 0);
      tick();
      checks++;
      if (out_commit_reg !== 5'd0) begin
         failures++;
         $display("FAIL order_young_first: reg=%0d want 0", out_commit_reg);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (out_commit_reg !== 5'd7 || out_commit_rob !== 4'd0 || out_commit_value !== 32'hA) begin
         failures++;
         $display("FAIL order_first: reg=%0d rob=%0d val=%0h want 7/0/a", out_commit_reg, out_commit_rob, out_commit_value);
      end
      tick();
      checks++;
      if (out_commit_reg !== 5'd9 || out_commit_rob !== 4'd1 || out_commit_value !== 32'hB) begin
         failures++;
         $display("FAIL order_second: reg=%0d rob=%0d val=%0h want 9/1/b", out_commit_reg, out_commit_rob, out_commit_value);
      end
      tick();
      checks++;
      if (out_commit_reg !== 5'd0) begin
         failures++;
         $display("FAIL order_drain: reg=%0d want 0", out_commit_reg);
      end
   endtask

   task automatic test_xbp;
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1, RW'(i), 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 1, 4'd0, 32'h55, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (out_commit_reg !== 5'd1 || out_commit_rob !== 4'd0 || out_commit_value !== 32'h55 || out_xbp !== 1'b1) begin
         failures++;
         $display("FAIL xbp_commit: reg=%0d rob=%0d val=%0h xbp=%0b want 1/0/55/1",
                  out_commit_reg, out_commit_rob, out_commit_value, out_xbp);
      end
      checks++;
      if (out_issue_rob !== 4'd0 || out_full !== 1'b0) begin
         failures++;
         $display("FAIL xbp_flush: tail=%0d full=%0b want 0/0", out_issue_rob, out_full);
      end
      drive(1, 5'd3, 1, 4'd1, 32'h99, 0);
      tick();
      checks++;
      if (out_xbp !== 1'b0 || out_commit_reg !== 5'd0 || out_issue_rob !== 4'd0) begin
         failures++;
         $display("FAIL xbp_ignore: xbp=%0b reg=%0d tail=%0d want 0/0/0", out_xbp, out_commit_reg, out_issue_rob);
      end
      drive(0, 0, 0, 0, 0, 0);
      in_query_rob1 = 4'd1;
      #1;
      checks++;
      if (out_query_ready1 !== 1'b0) begin
         failures++;
         $display("FAIL xbp_cdb_dropped: ready=%0b want 0", out_query_ready1);
      end
      drive(1, 5'd6, 0, 0, 0, 0);
      tick();
      checks++;
      if (out_issue_rob !== 4'd1) begin
         failures++;
         $display("FAIL xbp_reissue: tail=%0d want 1", out_issue_rob);
      end
      drive(0, 0, 1, 4'd0, 32'h66, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (out_commit_reg !== 5'd6 || out_commit_rob !== 4'd0 || out_commit_value !== 32'h66) begin
         failures++;
         $display("FAIL xbp_resume: reg=%0d rob=%0d val=%0h want 6/0/66", out_commit_reg, out_commit_rob, out_commit_value);
      end
      in_query_rob1 = 0;
   endtask

   task automatic test_query;
      logic exp_rdy;
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         drive(1, RW'(i + 10), 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 1, 4'd2, 32'hBEEF, 0);
      in_query_rob1 = 4'd2;
      in_query_rob2 = 4'd0;
      #1;
`ifdef ROB_CDB_BYPASS_EN
      exp_rdy = 1'b1;
`else
      exp_rdy = 1'b0;
`endif
      checks++;
      if (out_query_ready1 !== exp_rdy || (exp_rdy && out_query_value1 !== 32'hBEEF)) begin
         failures++;
         $display("FAIL query_same_cycle: ready=%0b val=%0h want %0b/beef", out_query_ready1, out_query_value1, exp_rdy);
      end
      checks++;
      if (out_query_ready2 !== 1'b0) begin
         failures++;
         $display("FAIL query_other: ready=%0b want 0", out_query_ready2);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (out_query_ready1 !== 1'b1 || out_query_value1 !== 32'hBEEF) begin
         failures++;
         $display("FAIL query_stored: ready=%0b val=%0h want 1/beef", out_query_ready1, out_query_value1);
      end
      in_query_rob1 = 0;
   endtask

   task automatic test_reset_midcycle;
      do_reset();
      for (int i = 2; i <= 4; i++) begin
         drive(1, RW'(i), 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 1, 4'd0, 32'h77, 0);
      tick();
      drive(1, 5'd8, 0, 0, 0, 0);
      tick();
      checks++;
      if (out_commit_reg !== 5'd2 || out_commit_value !== 32'h77 || out_issue_rob !== 4'd4) begin
         failures++;
         $display("FAIL mid_setup: reg=%0d val=%0h tail=%0d want 2/77/4", out_commit_reg, out_commit_value, out_issue_rob);
      end
      drive(0, 0, 0, 0, 0, 0);
      in_query_rob1 = 4'd1;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_commit_reg !== 5'd0 || out_commit_rob !== 4'd0 || out_commit_value !== 32'd0 || out_xbp !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_commit: reg=%0d rob=%0d val=%0h xbp=%0b want 0",
                  out_commit_reg, out_commit_rob, out_commit_value, out_xbp);
      end
      checks++;
      if (out_full !== 1'b0 || out_issue_rob !== 4'd0 || out_query_ready1 !== 1'b0 || out_query_value1 !== 32'd0) begin
         failures++;
         $display("FAIL mid_reset_state: full=%0b tail=%0d qrdy=%0b qval=%0h want 0",
                  out_full, out_issue_rob, out_query_ready1, out_query_value1);
      end
      #1;
      rst_n = 1'b1;
      in_query_rob1 = 0;
   endtask

   task automatic test_random;
      int          qt, ci;
      bit          ex_rdy, hit;
      logic [31:0] ex_val;
      bit          was_flush, do_commit, full;
      do_reset();
      mq.delete();
      m_next_tag  = 0;
      m_flush_cyc = 0;
      e_commit    = 0;
      e_reg = 0; e_rob = 0; e_val = 0; e_xbp = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         rdy               = ($urandom % 10) != 0;
         in_issue_flag     = ($urandom % 10) < 6;
         in_issue_dest_reg = RW'($urandom_range(1, 31));
         in_cdb_flag       = ($urandom % 2) == 1;
         if (mq.size() > 0 && ($urandom % 4) != 0) begin
            ci = $urandom_range(0, mq.size() - 1);
            in_cdb_rob = AW'(mq[ci].tag);
         end else
            in_cdb_rob = AW'($urandom % DEPTH);
         in_cdb_value  = $urandom;
         in_cdb_xbp    = ($urandom % 24) == 0;
         qt            = $urandom % DEPTH;
         in_query_rob1 = AW'(qt);
         in_query_rob2 = AW'($urandom % DEPTH);
         #1;
         ex_rdy = 0;
         ex_val = 0;
         foreach (mq[k]) if (mq[k].tag == qt && mq[k].fin) begin
            ex_rdy = 1;
            ex_val = mq[k].val;
         end
`ifdef ROB_CDB_BYPASS_EN
         if (in_cdb_flag && int'(in_cdb_rob) == qt) begin
            ex_rdy = 1;
            ex_val = in_cdb_value;
         end
`endif
         checks++;
         if (out_query_ready1 !== ex_rdy || (ex_rdy && out_query_value1 !== ex_val)) begin
            failures++;
            $display("FAIL rand_query cyc=%0d tag=%0d: ready=%0b val=%0h want %0b/%0h",
                     cyc, qt, out_query_ready1, out_query_value1, ex_rdy, ex_val);
         end
         tick();
         if (rdy) begin
            e_reg = 0;
            e_xbp = 0;
            was_flush   = m_flush_cyc;
            m_flush_cyc = 0;
            do_commit   = mq.size() > 0 && mq[0].fin;
            full        = mq.size() == DEPTH;
            if (do_commit) begin
               e_commit = 1;
               e_reg = mq[0].dst;
               e_rob = 4'(mq[0].tag);
               e_val = mq[0].val;
               e_xbp = mq[0].bad;
            end
            if (do_commit && mq[0].bad) begin
               mq.delete();
               m_next_tag  = 0;
               m_flush_cyc = 1;
            end else begin
               if (in_cdb_flag && !was_flush)
                  foreach (mq[k]) if (mq[k].tag == int'(in_cdb_rob)) begin
                     mq[k].fin = 1;
                     mq[k].val = in_cdb_value;
                     mq[k].bad = in_cdb_xbp;
                  end
               if (do_commit) void'(mq.pop_front());
               if (in_issue_flag && !full && !was_flush) begin
                  mq.push_back('{tag: m_next_tag, dst: in_issue_dest_reg, fin: 0, val: 0, bad: 0});
                  m_next_tag = (m_next_tag + 1) % DEPTH;
               end
            end
         end
         checks++;
         if (out_commit_reg !== e_reg || out_xbp !== e_xbp) begin
            failures++;
            $display("FAIL rand_commit cyc=%0d: reg=%0d xbp=%0b want %0d/%0b", cyc, out_commit_reg, out_xbp, e_reg, e_xbp);
         end
         checks++;
         if (e_commit && (out_commit_rob !== e_rob || out_commit_value !== e_val)) begin
            failures++;
            $display("FAIL rand_commit_data cyc=%0d: rob=%0d val=%0h want %0d/%0h",
                     cyc, out_commit_rob, out_commit_value, e_rob, e_val);
         end
         checks++;
         if (out_full !== (mq.size() == DEPTH) || int'(out_issue_rob) != m_next_tag) begin
            failures++;
            $display("FAIL rand_ptr cyc=%0d: full=%0b tail=%0d want %0b/%0d",
                     cyc, out_full, out_issue_rob, (mq.size() == DEPTH), m_next_tag);
         end
      end
      rdy = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_commit_basic();
      test_order();
      test_xbp();
      test_query();
      test_reset_midcycle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
